// File: rtl/writeback_stage.sv
// Registered writeback stage: selects ALU / PC+4 / load data, extracts and extends
// sub-word loads, stalls while a load waits for its memory acknowledge.
module writeback_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int OFF_W  = $clog2(XLEN/8)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [XLEN-1:0]   alu_value,
  input  logic [XLEN-1:0]   pc_4_value,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic              read_pc_4,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  input  logic [OFF_W-1:0]  byte_offset,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              load_err
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t              state;
  logic [REG_AW-1:0]   pend_rd;
  logic                pend_we;
  logic [1:0]          pend_size;
  logic                pend_uns;
  logic [OFF_W-1:0]    pend_off;

  logic                accept;
  logic                is_load;

  assign ready_out = (state == IDLE);
  assign accept    = valid_in & ready_out;
  assign is_load   = mem_to_reg & ~read_pc_4;

  // While waiting, the load is described by the captured fields, not the live inputs.
  logic [1:0]          ld_size;
  logic                ld_uns;
  logic [OFF_W-1:0]    ld_off;

  always_comb begin
    ld_size = load_size;
    ld_uns  = load_unsigned;
    ld_off  = byte_offset;
    if (state == WAIT_MEM) begin
      ld_size = pend_size;
      ld_uns  = pend_uns;
      ld_off  = pend_off;
    end
  end

  // Clearing low offset bits gives the containing half/word; shifting by it puts the field at bit 0.
  logic [OFF_W-1:0]    half_off;
  logic [OFF_W-1:0]    word_off;
  logic [XLEN-1:0]     sh_byte;
  logic [XLEN-1:0]     sh_half;
  logic [XLEN-1:0]     sh_word;
  logic [XLEN-1:0]     load_value;
  logic                load_bad;
  logic                sign;

  always_comb begin
    half_off   = ld_off & ~OFF_W'(1);
    word_off   = ld_off & ~OFF_W'(3);
    sh_byte    = mem_data >> {ld_off, 3'b000};
    sh_half    = mem_data >> {half_off, 3'b000};
    sh_word    = mem_data >> {word_off, 3'b000};
    load_value = '0;
    load_bad   = 1'b0;
    sign       = 1'b0;
    case (ld_size)
      2'b00: begin
        sign             = ~ld_uns & sh_byte[7];
        load_value       = {XLEN{sign}};
        load_value[7:0]  = sh_byte[7:0];
      end
      2'b01: begin
        sign             = ~ld_uns & sh_half[15];
        load_value       = {XLEN{sign}};
        load_value[15:0] = sh_half[15:0];
        load_bad         = ld_off[0];
      end
      2'b10: begin
        sign             = ~ld_uns & sh_word[31];
        load_value       = {XLEN{sign}};
        load_value[31:0] = sh_word[31:0];
        load_bad         = |ld_off[1:0];
      end
      default: begin
        load_bad         = 1'b1;
      end
    endcase
  end

  // One retirement per cycle at most: an accepted non-load, a load acked on accept, or a pending load's ack.
  logic                done;
  logic [REG_AW-1:0]   done_rd;
  logic                done_wr;
  logic [XLEN-1:0]     done_data;
  logic                done_err;

  always_comb begin
    done      = 1'b0;
    done_rd   = rd_addr;
    done_wr   = reg_write;
    done_data = read_pc_4 ? pc_4_value : alu_value;
    done_err  = 1'b0;
    if (state == WAIT_MEM) begin
      done      = mem_ack;
      done_rd   = pend_rd;
      done_wr   = pend_we;
      done_data = load_value;
      done_err  = load_bad;
    end else if (accept) begin
      if (is_load) begin
        done      = mem_ack;
        done_data = load_value;
        done_err  = load_bad;
      end else begin
        done      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      pend_rd   <= '0;
      pend_we   <= 1'b0;
      pend_size <= 2'b00;
      pend_uns  <= 1'b0;
      pend_off  <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      load_err  <= 1'b0;
    end else begin
      rf_we    <= 1'b0;
      load_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && is_load && !mem_ack) begin
            state     <= WAIT_MEM;
            pend_rd   <= rd_addr;
            pend_we   <= reg_write;
            pend_size <= load_size;
            pend_uns  <= load_unsigned;
            pend_off  <= byte_offset;
          end
        end
        WAIT_MEM: begin
          if (mem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (done) begin
        rf_waddr <= done_rd;
        rf_wdata <= done_data;
        rf_we    <= done_wr & (|done_rd) & ~done_err;
        load_err <= done_err;
      end
    end
  end

endmodule
